// File: rtl/hdb3_pkg.sv
// Constants and state encoding shared by the HDB3 line path PRBS7 source and checker.
package hdb3_pkg;

  localparam int unsigned PRBS7_W      = 7;
  localparam int unsigned PRBS7_TAP_HI = 6;
  localparam int unsigned PRBS7_TAP_LO = 5;

  // An all-zero register is the LFSR lock-up state and never a valid seed.
  localparam logic [PRBS7_W-1:0] PRBS7_ZERO = '0;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } prbs_state_e;

  function automatic logic prbs7_next(input logic [PRBS7_W-1:0] s);
    return s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO];
  endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// PRBS7 (x^7+x^6+1) shift register: shifts in either an external bit or its own feedback.
module prbs7_lfsr
  import hdb3_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_load,
  input  logic               i_din,
  output logic [PRBS7_W-1:0] o_state,
  output logic               o_pred
);

  logic [PRBS7_W-1:0] r_lfsr;
  logic               w_pred;
  logic               w_shift_in;

  assign w_pred     = prbs7_next(r_lfsr);
  assign w_shift_in = i_load ? i_din : w_pred;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= '0;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[PRBS7_W-2:0], w_shift_in};
    end
  end

  assign o_state = r_lfsr;
  assign o_pred  = w_pred;

endmodule

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS7 checker: hunts for lock on the decoded stream, then counts bit errors
// and drops lock when too many errors land in one window.
module prbs7_checker
  import hdb3_pkg::*;
#(
  parameter int unsigned SYNC_LEN = 16,
  parameter int unsigned WIN_LEN  = 64,
  parameter int unsigned LOSS_ERR = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_data,
  input  logic             i_clr,
  output logic             o_lock,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_bit_cnt
);

  localparam int unsigned MATCH_W = $clog2(SYNC_LEN + 1);
  localparam int unsigned WIN_W   = $clog2(WIN_LEN);
  localparam int unsigned WERR_W  = $clog2(LOSS_ERR + 1);

  prbs_state_e        r_state, w_state_nxt;
  logic [2:0]         r_fill, w_fill_nxt;
  logic [MATCH_W-1:0] r_match, w_match_nxt, w_match_inc;
  logic [WIN_W-1:0]   r_win, w_win_nxt;
  logic [WERR_W-1:0]  r_win_err, w_win_err_nxt, w_win_err_upd;
  logic               r_lock, w_lock_nxt;
  logic               r_err, w_err_nxt;
  logic [CNT_W-1:0]   r_err_cnt, r_bit_cnt;

  logic [PRBS7_W-1:0] w_lfsr;
  logic               w_pred;
  logic               w_hunt;
  logic               w_bit_err;
  logic               w_win_wrap;
  logic               w_cnt_en;

  assign w_hunt = (r_state == HUNT);

  // In HUNT the reference is reloaded from the line; in LOCK it free-runs on its own feedback.
  prbs7_lfsr u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_load  (w_hunt),
    .i_din   (i_data),
    .o_state (w_lfsr),
    .o_pred  (w_pred)
  );

  assign w_bit_err     = (r_state == LOCK) && (i_data != w_pred);
  assign w_match_inc   = r_match + 1'b1;
  assign w_win_wrap    = (r_win == WIN_W'(WIN_LEN - 1));
  // The error on the wrap bit opens the next window rather than closing the old one.
  assign w_win_err_upd = w_win_wrap ? WERR_W'(w_bit_err) : r_win_err + WERR_W'(w_bit_err);
  assign w_cnt_en      = i_en && (r_state == LOCK);

  always_comb begin
    w_state_nxt   = r_state;
    w_fill_nxt    = r_fill;
    w_match_nxt   = r_match;
    w_win_nxt     = r_win;
    w_win_err_nxt = r_win_err;
    w_lock_nxt    = r_lock;
    w_err_nxt     = 1'b0;
    if (i_en) begin
      case (r_state)
        HUNT: begin
          if (r_fill != 3'd7) begin
            w_fill_nxt = r_fill + 3'd1;
          end else if ((i_data == w_pred) && (w_lfsr != PRBS7_ZERO)) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == MATCH_W'(SYNC_LEN)) begin
              w_state_nxt   = LOCK;
              w_lock_nxt    = 1'b1;
              w_win_nxt     = '0;
              w_win_err_nxt = '0;
            end
          end else begin
            w_match_nxt = '0;
          end
        end
        LOCK: begin
          w_err_nxt     = w_bit_err;
          w_win_nxt     = w_win_wrap ? '0 : r_win + 1'b1;
          w_win_err_nxt = w_win_err_upd;
          if (w_win_err_upd == WERR_W'(LOSS_ERR)) begin
            w_state_nxt = HUNT;
            w_lock_nxt  = 1'b0;
            w_fill_nxt  = '0;
            w_match_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_lock_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill    <= '0;
      r_match   <= '0;
      r_win     <= '0;
      r_win_err <= '0;
      r_lock    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_fill    <= w_fill_nxt;
      r_match   <= w_match_nxt;
      r_win     <= w_win_nxt;
      r_win_err <= w_win_err_nxt;
      r_lock    <= w_lock_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Clear wins over a same-cycle increment; it is a management action and ignores i_en.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (i_clr) begin
      r_err_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (w_cnt_en) begin
      if (r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_bit_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign o_lock    = r_lock;
  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;
  assign o_bit_cnt = r_bit_cnt;

endmodule
